// File: rtl/cpu_ctrl_defs.sv
// Shared control-unit definitions: instruction opcodes, ALU codes, FSM states
// and the strobe bundle passed around inside the sequencer.
package cpu_ctrl_defs;

   localparam logic [4:0] OP_LD   = 5'd0;
   localparam logic [4:0] OP_LDI  = 5'd1;
   localparam logic [4:0] OP_ST   = 5'd2;
   localparam logic [4:0] OP_ADD  = 5'd3;
   localparam logic [4:0] OP_SUB  = 5'd4;
   localparam logic [4:0] OP_SHR  = 5'd5;
   localparam logic [4:0] OP_SHL  = 5'd6;
   localparam logic [4:0] OP_ROR  = 5'd7;
   localparam logic [4:0] OP_ROL  = 5'd8;
   localparam logic [4:0] OP_AND  = 5'd9;
   localparam logic [4:0] OP_OR   = 5'd10;
   localparam logic [4:0] OP_ADDI = 5'd11;
   localparam logic [4:0] OP_ANDI = 5'd12;
   localparam logic [4:0] OP_ORI  = 5'd13;
   localparam logic [4:0] OP_MUL  = 5'd14;
   localparam logic [4:0] OP_DIV  = 5'd15;
   localparam logic [4:0] OP_NEG  = 5'd16;
   localparam logic [4:0] OP_NOT  = 5'd17;
   localparam logic [4:0] OP_BR   = 5'd18;
   localparam logic [4:0] OP_JR   = 5'd19;
   localparam logic [4:0] OP_IN   = 5'd21;
   localparam logic [4:0] OP_OUT  = 5'd22;
   localparam logic [4:0] OP_MFHI = 5'd23;
   localparam logic [4:0] OP_MFLO = 5'd24;
   localparam logic [4:0] OP_NOP  = 5'd25;
   localparam logic [4:0] OP_HALT = 5'd26;

   localparam logic [4:0] ALU_AND = 5'd0;
   localparam logic [4:0] ALU_OR  = 5'd1;
   localparam logic [4:0] ALU_ADD = 5'd2;
   localparam logic [4:0] ALU_SUB = 5'd3;
   localparam logic [4:0] ALU_MUL = 5'd4;
   localparam logic [4:0] ALU_DIV = 5'd5;
   localparam logic [4:0] ALU_SHR = 5'd6;
   localparam logic [4:0] ALU_SHL = 5'd7;
   localparam logic [4:0] ALU_ROR = 5'd8;
   localparam logic [4:0] ALU_ROL = 5'd9;
   localparam logic [4:0] ALU_NEG = 5'd10;
   localparam logic [4:0] ALU_NOT = 5'd11;
   localparam logic [4:0] ALU_INC = 5'd12;

   typedef enum logic [3:0] {
      S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
      S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
      S_HALT = 4'd8
   } state_t;

   typedef enum logic [3:0] {
      C_LD, C_LDI, C_ST, C_RTYPE, C_IMM, C_UNARY, C_MULDIV, C_BR,
      C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
   } iclass_t;

   typedef struct packed {
      logic pc_out, pc_in, inc_pc;
      logic mar_in, mdr_in, mdr_out, read, write;
      logic ir_in, y_in, z_in, zlow_out, zhigh_out;
      logic hi_in, lo_in, hi_out, lo_out;
      logic gra, grb, grc, r_in, r_out, ba_out, c_out;
      logic con_in, outport_in, inport_out;
   } strobes_t;

endpackage

// File: rtl/ctrl_op_decode.sv
// Combinational opcode decoder: instruction class, ALU operation and the
// index of the final execute step for each opcode.
module ctrl_op_decode
   import cpu_ctrl_defs::*;
#(
   parameter int OPW  = 5,
   parameter int ALUW = 5
) (
   input  logic [OPW-1:0]  opcode,
   output iclass_t         cls,
   output logic [ALUW-1:0] alu,
   output logic [2:0]      last_step
);

   logic [4:0] op5;
   assign op5 = 5'(opcode);

   always_comb begin
      cls       = C_NOP;
      alu       = ALUW'(ALU_ADD);
      last_step = 3'd2;
      case (op5)
         OP_LD:   begin cls = C_LD;     last_step = 3'd7; end
         OP_LDI:  begin cls = C_LDI;    last_step = 3'd5; end
         OP_ST:   begin cls = C_ST;     last_step = 3'd7; end
         OP_ADD:  begin cls = C_RTYPE;  last_step = 3'd5; alu = ALUW'(ALU_ADD); end
         OP_SUB:  begin cls = C_RTYPE;  last_step = 3'd5; alu = ALUW'(ALU_SUB); end
         OP_SHR:  begin cls = C_RTYPE;  last_step = 3'd5; alu = ALUW'(ALU_SHR); end
         OP_SHL:  begin cls = C_RTYPE;  last_step = 3'd5; alu = ALUW'(ALU_SHL); end
         OP_ROR:  begin cls = C_RTYPE;  last_step = 3'd5; alu = ALUW'(ALU_ROR); end
         OP_ROL:  begin cls = C_RTYPE;  last_step = 3'd5; alu = ALUW'(ALU_ROL); end
         OP_AND:  begin cls = C_RTYPE;  last_step = 3'd5; alu = ALUW'(ALU_AND); end
         OP_OR:   begin cls = C_RTYPE;  last_step = 3'd5; alu = ALUW'(ALU_OR);  end
         OP_ADDI: begin cls = C_IMM;    last_step = 3'd5; alu = ALUW'(ALU_ADD); end
         OP_ANDI: begin cls = C_IMM;    last_step = 3'd5; alu = ALUW'(ALU_AND); end
         OP_ORI:  begin cls = C_IMM;    last_step = 3'd5; alu = ALUW'(ALU_OR);  end
         OP_MUL:  begin cls = C_MULDIV; last_step = 3'd6; alu = ALUW'(ALU_MUL); end
         OP_DIV:  begin cls = C_MULDIV; last_step = 3'd6; alu = ALUW'(ALU_DIV); end
         OP_NEG:  begin cls = C_UNARY;  last_step = 3'd4; alu = ALUW'(ALU_NEG); end
         OP_NOT:  begin cls = C_UNARY;  last_step = 3'd4; alu = ALUW'(ALU_NOT); end
         OP_BR:   begin cls = C_BR;     last_step = 3'd6; end
         OP_JR:   begin cls = C_JR;     last_step = 3'd3; end
         OP_IN:   begin cls = C_IN;     last_step = 3'd3; end
         OP_OUT:  begin cls = C_OUT;    last_step = 3'd3; end
         OP_MFHI: begin cls = C_MFHI;   last_step = 3'd3; end
         OP_MFLO: begin cls = C_MFLO;   last_step = 3'd3; end
         OP_HALT: begin cls = C_HALT;   last_step = 3'd2; end
         default: begin cls = C_NOP;    last_step = 3'd2; end
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for Datapath2: one state per clock, fetch in
// T0-T2, opcode-dependent execute steps in T3-T7, and a HALT state.
module control_sequencer
   import cpu_ctrl_defs::*;
#(
   parameter int          OPW      = 5,
   parameter int          ALUW     = 5,
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input  logic            clk,
   input  logic            clr,
   input  logic [31:0]     IR,
   input  logic            CON_FF,
   input  logic            Stop,
   output logic            PCout,
   output logic            PCin,
   output logic            IncPC,
   output logic            MARin,
   output logic            MDRin,
   output logic            MDRout,
   output logic            Read,
   output logic            Write,
   output logic            IRin,
   output logic            Yin,
   output logic            Zin,
   output logic            Zlowout,
   output logic            Zhighout,
   output logic            HIin,
   output logic            LOin,
   output logic            HIout,
   output logic            LOout,
   output logic            Gra,
   output logic            Grb,
   output logic            Grc,
   output logic            Rin,
   output logic            Rout,
   output logic            BAout,
   output logic            Cout,
   output logic            CONin,
   output logic            OutportIn,
   output logic            InportOut,
   output logic [ALUW-1:0] OpCode,
   output logic            Run
);

   // PC reset is owned by the datapath; the value is kept here for reference only.
   localparam logic [31:0] unused_reset_pc = RESET_PC;

   state_t          state, state_nxt;
   logic            fresh;
   logic            stop_pend;
   logic [ALUW-1:0] op_hold, op_now;
   strobes_t        s;
   iclass_t         cls;
   logic [ALUW-1:0] cls_alu;
   logic [2:0]      last_step;
   logic            unused_ir;

   assign unused_ir = ^IR[31-OPW:0];

   ctrl_op_decode #(.OPW(OPW), .ALUW(ALUW)) u_decode (
      .opcode    (IR[31 -: OPW]),
      .cls       (cls),
      .alu       (cls_alu),
      .last_step (last_step)
   );

   // fresh marks the quiet first cycle after clr; T0 strobes wait one cycle.
   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= S_T0;
         fresh     <= 1'b1;
         stop_pend <= 1'b0;
         op_hold   <= '0;
      end else begin
         state <= state_nxt;
         fresh <= 1'b0;
         if (state_nxt == S_HALT)
            stop_pend <= 1'b0;
         else if (Stop && state != S_HALT)
            stop_pend <= 1'b1;
         if (s.z_in)
            op_hold <= op_now;
      end
   end

   always_comb begin
      state_nxt = state;
      s         = '0;
      op_now    = ALUW'(ALU_INC);

      case (state)
         S_T0: if (!fresh) begin
            state_nxt = S_T1;
            s.pc_out = 1'b1; s.mar_in = 1'b1; s.inc_pc = 1'b1; s.z_in = 1'b1;
            op_now   = ALUW'(ALU_INC);
         end
         S_T1: begin
            state_nxt = S_T2;
            s.zlow_out = 1'b1; s.pc_in = 1'b1; s.read = 1'b1; s.mdr_in = 1'b1;
         end
         S_HALT: state_nxt = S_HALT;
         default: begin
            if (state[2:0] == last_step || state == S_T7)
               state_nxt = (cls == C_HALT || Stop || stop_pend) ? S_HALT : S_T0;
            else
               state_nxt = state_t'(state + 4'd1);
         end
      endcase

      case (state)
         S_T2: begin s.mdr_out = 1'b1; s.ir_in = 1'b1; end
         S_T3: case (cls)
            C_LD, C_LDI, C_ST: begin s.grb = 1'b1; s.ba_out = 1'b1; s.y_in = 1'b1; end
            C_RTYPE, C_IMM:    begin s.grb = 1'b1; s.r_out = 1'b1; s.y_in = 1'b1; end
            C_UNARY:  begin s.grb = 1'b1; s.r_out = 1'b1; s.z_in = 1'b1; op_now = cls_alu; end
            C_MULDIV: begin s.gra = 1'b1; s.r_out = 1'b1; s.y_in = 1'b1; end
            C_BR:     begin s.gra = 1'b1; s.r_out = 1'b1; s.con_in = 1'b1; end
            C_JR:     begin s.gra = 1'b1; s.r_out = 1'b1; s.pc_in = 1'b1; end
            C_IN:     begin s.inport_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
            C_OUT:    begin s.gra = 1'b1; s.r_out = 1'b1; s.outport_in = 1'b1; end
            C_MFHI:   begin s.hi_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
            C_MFLO:   begin s.lo_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
            default: ;
         endcase
         S_T4: case (cls)
            C_LD, C_LDI, C_ST: begin s.c_out = 1'b1; s.z_in = 1'b1; op_now = ALUW'(ALU_ADD); end
            C_RTYPE:  begin s.grc = 1'b1; s.r_out = 1'b1; s.z_in = 1'b1; op_now = cls_alu; end
            C_IMM:    begin s.c_out = 1'b1; s.z_in = 1'b1; op_now = cls_alu; end
            C_UNARY:  begin s.zlow_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
            C_MULDIV: begin s.grb = 1'b1; s.r_out = 1'b1; s.z_in = 1'b1; op_now = cls_alu; end
            C_BR:     begin s.pc_out = 1'b1; s.y_in = 1'b1; end
            default: ;
         endcase
         S_T5: case (cls)
            C_LD, C_ST:            begin s.zlow_out = 1'b1; s.mar_in = 1'b1; end
            C_LDI, C_RTYPE, C_IMM: begin s.zlow_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
            C_MULDIV:              begin s.zlow_out = 1'b1; s.lo_in = 1'b1; end
            C_BR:     begin s.c_out = 1'b1; s.z_in = 1'b1; op_now = ALUW'(ALU_ADD); end
            default: ;
         endcase
         S_T6: case (cls)
            C_LD:     begin s.read = 1'b1; s.mdr_in = 1'b1; end
            C_ST:     begin s.gra = 1'b1; s.r_out = 1'b1; s.mdr_in = 1'b1; end
            C_MULDIV: begin s.zhigh_out = 1'b1; s.hi_in = 1'b1; end
            C_BR:     if (CON_FF) begin s.zlow_out = 1'b1; s.pc_in = 1'b1; end
            default: ;
         endcase
         S_T7: case (cls)
            C_LD:    begin s.mdr_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1; end
            C_ST:    s.write = 1'b1;
            default: ;
         endcase
         default: ;
      endcase
   end

   assign PCout     = s.pc_out;
   assign PCin      = s.pc_in;
   assign IncPC     = s.inc_pc;
   assign MARin     = s.mar_in;
   assign MDRin     = s.mdr_in;
   assign MDRout    = s.mdr_out;
   assign Read      = s.read;
   assign Write     = s.write;
   assign IRin      = s.ir_in;
   assign Yin       = s.y_in;
   assign Zin       = s.z_in;
   assign Zlowout   = s.zlow_out;
   assign Zhighout  = s.zhigh_out;
   assign HIin      = s.hi_in;
   assign LOin      = s.lo_in;
   assign HIout     = s.hi_out;
   assign LOout     = s.lo_out;
   assign Gra       = s.gra;
   assign Grb       = s.grb;
   assign Grc       = s.grc;
   assign Rin       = s.r_in;
   assign Rout      = s.r_out;
   assign BAout     = s.ba_out;
   assign Cout      = s.c_out;
   assign CONin     = s.con_in;
   assign OutportIn = s.outport_in;
   assign InportOut = s.inport_out;
   assign OpCode    = s.z_in ? op_now : op_hold;
   assign Run       = (state != S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: instruction-length table, directed corner
// sequences and random instruction streams checked against a step-list model.
module tb_control_sequencer;

   typedef logic [26:0] sv_t;
   localparam sv_t PCOUT = 27'd1 << 0,  PCIN   = 27'd1 << 1,  INCPC  = 27'd1 << 2;
   localparam sv_t MARIN = 27'd1 << 3,  MDRIN  = 27'd1 << 4,  MDROUT = 27'd1 << 5;
   localparam sv_t READ  = 27'd1 << 6,  WRITE  = 27'd1 << 7,  IRIN   = 27'd1 << 8;
   localparam sv_t YIN   = 27'd1 << 9,  ZIN    = 27'd1 << 10, ZLOW   = 27'd1 << 11;
   localparam sv_t ZHIGH = 27'd1 << 12, HIIN   = 27'd1 << 13, LOIN   = 27'd1 << 14;
   localparam sv_t HIOUT = 27'd1 << 15, LOOUT  = 27'd1 << 16, GRA    = 27'd1 << 17;
   localparam sv_t GRB   = 27'd1 << 18, GRC    = 27'd1 << 19, RIN    = 27'd1 << 20;
   localparam sv_t ROUT  = 27'd1 << 21, BAOUT  = 27'd1 << 22, COUT   = 27'd1 << 23;
   localparam sv_t CONIN = 27'd1 << 24, OUTIN  = 27'd1 << 25, INOUT  = 27'd1 << 26;
   localparam sv_t BUS   = PCOUT | ZLOW | ZHIGH | MDROUT | ROUT | BAOUT | COUT | HIOUT | LOOUT | INOUT;
   localparam sv_t T0SIG = PCOUT | MARIN | INCPC | ZIN;

   logic clk, clr, CON_FF, Stop;
   logic [31:0] IR;
   logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin;
   logic Zlowout, Zhighout, HIin, LOin, HIout, LOout, Gra, Grb, Grc, Rin, Rout;
   logic BAout, Cout, CONin, OutportIn, InportOut, Run;
   logic [4:0] OpCode;
   sv_t act;

   control_sequencer #(.OPW(5), .ALUW(5), .RESET_PC(32'd0)) dut (
      .clk(clk), .clr(clr), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
      .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin), .Zin(Zin),
      .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
      .HIout(HIout), .LOout(LOout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
      .Rout(Rout), .BAout(BAout), .Cout(Cout), .CONin(CONin),
      .OutportIn(OutportIn), .InportOut(InportOut), .OpCode(OpCode), .Run(Run)
   );

   assign act = {InportOut, OutportIn, CONin, Cout, BAout, Rout, Rin, Grc, Grb, Gra,
                 LOout, HIout, LOin, HIin, Zhighout, Zlowout, Zin, Yin, IRin, Write,
                 Read, MDRout, MDRin, MARin, IncPC, PCin, PCout};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time exhausted, required completion");
      $fatal(1);
   end

   typedef struct { sv_t s; int alu; } step_t;
   typedef struct { logic [4:0] op; bit con; int len; bit halts; } vec_t;

   step_t      exp_q[$];
   vec_t       tbl[16];
   int         vec_cnt = 0;
   int         err_cnt = 0;
   logic [4:0] last_alu = 5'd0;

   function automatic int alu_of(input logic [4:0] op);
      case (op)
         5'd3: return 2;   5'd4: return 3;   5'd5: return 6;   5'd6: return 7;
         5'd7: return 8;   5'd8: return 9;   5'd9: return 0;   5'd10: return 1;
         5'd11: return 2;  5'd12: return 0;  5'd13: return 1;  5'd14: return 4;
         5'd15: return 5;  5'd16: return 10; 5'd17: return 11;
         default: return 2;
      endcase
   endfunction

   function automatic void add(input sv_t s, input int a);
      step_t st;
      st.s = s;
      st.alu = a;
      exp_q.push_back(st);
   endfunction

   // Expected per-cycle strobes for one instruction, fetch included.
   function automatic void build(input logic [4:0] op, input bit con);
      int a;
      a = alu_of(op);
      exp_q.delete();
      add(PCOUT | MARIN | INCPC | ZIN, 12);
      add(ZLOW | PCIN | READ | MDRIN, -1);
      add(MDROUT | IRIN, -1);
      if (op == 5'd0 || op == 5'd1 || op == 5'd2) begin
         add(GRB | BAOUT | YIN, -1);
         add(COUT | ZIN, 2);
         if (op == 5'd1) add(ZLOW | GRA | RIN, -1);
         else            add(ZLOW | MARIN, -1);
         if (op == 5'd0) begin add(READ | MDRIN, -1); add(MDROUT | GRA | RIN, -1); end
         if (op == 5'd2) begin add(GRA | ROUT | MDRIN, -1); add(WRITE, -1); end
      end else if (op >= 5'd3 && op <= 5'd10) begin
         add(GRB | ROUT | YIN, -1); add(GRC | ROUT | ZIN, a); add(ZLOW | GRA | RIN, -1);
      end else if (op >= 5'd11 && op <= 5'd13) begin
         add(GRB | ROUT | YIN, -1); add(COUT | ZIN, a); add(ZLOW | GRA | RIN, -1);
      end else if (op == 5'd14 || op == 5'd15) begin
         add(GRA | ROUT | YIN, -1); add(GRB | ROUT | ZIN, a);
         add(ZLOW | LOIN, -1); add(ZHIGH | HIIN, -1);
      end else if (op == 5'd16 || op == 5'd17) begin
         add(GRB | ROUT | ZIN, a); add(ZLOW | GRA | RIN, -1);
      end else if (op == 5'd18) begin
         add(GRA | ROUT | CONIN, -1); add(PCOUT | YIN, -1); add(COUT | ZIN, 2);
         add(con ? (ZLOW | PCIN) : sv_t'(0), -1);
      end else if (op == 5'd19) add(GRA | ROUT | PCIN, -1);
      else if (op == 5'd21) add(INOUT | GRA | RIN, -1);
      else if (op == 5'd22) add(GRA | ROUT | OUTIN, -1);
      else if (op == 5'd23) add(HIOUT | GRA | RIN, -1);
      else if (op == 5'd24) add(LOOUT | GRA | RIN, -1);
   endfunction

   task automatic check(input sv_t es, input bit er, input int ea, input string nm);
      logic [4:0] eop;
      eop = (ea >= 0) ? 5'(ea) : last_alu;
      vec_cnt++;
      if (act !== es || Run !== er || OpCode !== eop || !$onehot0(act & BUS)) begin
         err_cnt++;
         $display("FAIL %s: got strobes=%h run=%b op=%0d, expected strobes=%h run=%b op=%0d",
                  nm, act, Run, OpCode, es, er, eop);
      end
      if (ea >= 0) last_alu = 5'(ea);
   endtask

   task automatic do_reset();
      clr = 1'b1;
      Stop = 1'b0;
      @(posedge clk); @(negedge clk);
      clr = 1'b0;
      last_alu = 5'd0;
      check('0, 1'b1, -1, "reset");
   endtask

   // IR is presented after T1 so the end-of-fetch decision sees the new opcode.
   task automatic run_instr(input logic [31:0] ir, input bit con, input int stop_at, input int abort_at);
      bit halts;
      build(ir[31:27], con);
      halts = (ir[31:27] == 5'd26) || (stop_at >= 0 && stop_at < exp_q.size());
      CON_FF = con;
      for (int i = 0; i < exp_q.size(); i++) begin
         @(posedge clk); @(negedge clk);
         check(exp_q[i].s, 1'b1, exp_q[i].alu, $sformatf("ir=%08h step%0d", ir, i));
         if (i == 1) IR = ir;
         Stop = (i == stop_at);
         if (i == abort_at) begin
            do_reset();
            return;
         end
      end
      if (halts) begin
         for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk);
            check('0, 1'b0, -1, "halt");
            Stop = 1'($urandom);
         end
         do_reset();
      end
   endtask

   initial begin
      int  n;
      bit  done;
      logic [31:0] r;

      clr = 1'b1; Stop = 1'b0; CON_FF = 1'b0; IR = 32'h0;

      tbl[0]  = '{5'd2,  1'b0, 8, 1'b0};  tbl[1]  = '{5'd3,  1'b0, 6, 1'b0};
      tbl[2]  = '{5'd1,  1'b0, 6, 1'b0};  tbl[3]  = '{5'd0,  1'b0, 8, 1'b0};
      tbl[4]  = '{5'd14, 1'b0, 7, 1'b0};  tbl[5]  = '{5'd15, 1'b0, 7, 1'b0};
      tbl[6]  = '{5'd16, 1'b0, 5, 1'b0};  tbl[7]  = '{5'd18, 1'b1, 7, 1'b0};
      tbl[8]  = '{5'd18, 1'b0, 7, 1'b0};  tbl[9]  = '{5'd19, 1'b0, 4, 1'b0};
      tbl[10] = '{5'd21, 1'b0, 4, 1'b0};  tbl[11] = '{5'd23, 1'b0, 4, 1'b0};
      tbl[12] = '{5'd25, 1'b0, 3, 1'b0};  tbl[13] = '{5'd20, 1'b0, 3, 1'b0};
      tbl[14] = '{5'd31, 1'b0, 3, 1'b0};  tbl[15] = '{5'd26, 1'b0, 3, 1'b1};

      for (int t = 0; t < 16; t++) begin
         do_reset();
         CON_FF = tbl[t].con;
         n = 0;
         done = 1'b0;
         while (!done && n < 20) begin
            @(posedge clk); @(negedge clk);
            n++;
            if (n == 2) IR = {tbl[t].op, 27'h0};
            if (n > 1 && (act == T0SIG || Run == 1'b0)) done = 1'b1;
         end
         vec_cnt++;
         if (!done || n - 1 != tbl[t].len || Run != !tbl[t].halts) begin
            err_cnt++;
            $display("FAIL length op=%0d: got %0d cycles run=%b, expected %0d cycles run=%b",
                     tbl[t].op, n - 1, Run, tbl[t].len, !tbl[t].halts);
         end
      end

      do_reset();
      run_instr(32'h12000090, 1'b0, -1, -1);
      run_instr(32'h19918000, 1'b0, -1, -1);
      run_instr({5'd18, 27'h0123}, 1'b1, -1, -1);
      run_instr({5'd18, 27'h0123}, 1'b0, -1, -1);
      run_instr({5'd14, 27'h0456}, 1'b0, -1, -1);
      run_instr({5'd26, 27'h0}, 1'b0, -1, -1);
      run_instr({5'd0, 27'h0789}, 1'b0, 4, -1);
      run_instr({5'd0, 27'h0789}, 1'b0, -1, 5);
      run_instr({5'd3, 27'h0abc}, 1'b0, -1, -1);

      for (int k = 0; k < 400; k++) begin
         r = $urandom;
         run_instr(r, 1'($urandom),
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1,
                   ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
